// File: rtl/usb4_lane_deskew_if.sv
// Lane-side and aligned-side signal bundle for the USB4 lane deskew buffer.
// The receiver front end drives the master side; the deskew block is the slave.
interface usb4_lane_deskew_if #(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8
);
  logic                          en;
  logic [NUM_LANES*DATA_W-1:0]   lane_data_in;
  logic [NUM_LANES-1:0]          lane_valid_in;
  logic [NUM_LANES*DATA_W-1:0]   data_out;
  logic                          valid_out;
  logic                          aligned;
  logic                          skew_err;
  logic [$clog2(DEPTH):0]        skew_value;

  modport master (
    output en, lane_data_in, lane_valid_in,
    input  data_out, valid_out, aligned, skew_err, skew_value
  );

  modport slave (
    input  en, lane_data_in, lane_valid_in,
    output data_out, valid_out, aligned, skew_err, skew_value
  );
endinterface

// File: rtl/usb4_lane_deskew.sv
// N-lane deskew buffer: aligns all lanes on a marker symbol using per-lane
// FIFOs, then pops one symbol per lane per cycle as a lane-aligned word.
module usb4_lane_deskew #(
  parameter int                NUM_LANES = 2,
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 8,
  parameter logic [DATA_W-1:0] MARKER    = DATA_W'('hF0)
) (
  input logic                clk,
  input logic                rst_n,
  usb4_lane_deskew_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, HUNT, ALIGNED, ERROR} state_t;

  state_t                      state_q, state_d;
  logic [DATA_W-1:0]           mem [NUM_LANES][DEPTH];
  logic [PW-1:0]               wr_ptr_q [NUM_LANES];
  logic [PW-1:0]               rd_ptr_q [NUM_LANES];
  logic [NUM_LANES-1:0]        captured_q, captured_d;
  logic [NUM_LANES-1:0]        push, empty, full;
  logic                        pop, flush, overflow, load_skew;
  logic [PW-1:0]               skew_cnt_q, skew_cnt_d, cur_skew;
  logic [NUM_LANES*DATA_W-1:0] head_data;

  always_comb begin
    empty     = '0;
    full      = '0;
    head_data = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      head_data[i*DATA_W +: DATA_W] = mem[i][rd_ptr_q[i][AW-1:0]];
    end
  end

  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    push       = '0;
    pop        = 1'b0;
    flush      = 1'b0;
    overflow   = 1'b0;
    load_skew  = 1'b0;
    skew_cnt_d = skew_cnt_q;
    // Skew seen by the current cycle: 0 on the first capture cycle, then one
    // more for every cycle since; a lane capturing now lands exactly on it.
    cur_skew   = (|captured_q) ? skew_cnt_q + 1'b1 : '0;

    case (state_q)
      IDLE: begin
        flush      = 1'b1;
        captured_d = '0;
        state_d    = HUNT;
      end
      HUNT: begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (bus.lane_valid_in[i] &&
              (captured_q[i] || bus.lane_data_in[i*DATA_W +: DATA_W] == MARKER)) begin
            push[i]       = 1'b1;
            captured_d[i] = 1'b1;
          end
        end
        if (|captured_d) skew_cnt_d = cur_skew;
        overflow = |(push & full);
        if (cur_skew == DEPTH_P || overflow) begin
          state_d = ERROR;
        end else if (&captured_d) begin
          state_d   = ALIGNED;
          load_skew = 1'b1;
        end
      end
      ALIGNED: begin
        push     = bus.lane_valid_in;
        pop      = ~|empty;
        overflow = !pop && |(push & full);
        if (overflow) state_d = ERROR;
      end
      default: begin
        flush = 1'b1;
      end
    endcase

    if (state_d == ERROR) begin
      flush      = 1'b1;
      push       = '0;
      pop        = 1'b0;
      load_skew  = 1'b0;
      captured_d = '0;
    end

    if (!bus.en) begin
      state_d    = IDLE;
      flush      = 1'b1;
      push       = '0;
      pop        = 1'b0;
      load_skew  = 1'b0;
      captured_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured_q     <= '0;
      skew_cnt_q     <= '0;
      bus.skew_value <= '0;
      bus.data_out   <= '0;
      bus.valid_out  <= 1'b0;
      bus.aligned    <= 1'b0;
      bus.skew_err   <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      captured_q    <= captured_d;
      skew_cnt_q    <= flush ? '0 : skew_cnt_d;
      bus.valid_out <= pop;
      bus.aligned   <= (state_d == ALIGNED);
      bus.skew_err  <= (state_d == ERROR);
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (flush) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
        end else begin
          if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (pop)     rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
      end
      if (!bus.en) begin
        bus.data_out   <= '0;
        bus.skew_value <= '0;
      end else begin
        if (pop)       bus.data_out   <= head_data;
        if (load_skew) bus.skew_value <= cur_skew;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (push[i]) mem[i][wr_ptr_q[i][AW-1:0]] <= bus.lane_data_in[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_usb4_lane_deskew.sv
// Directed bench for usb4_lane_deskew: 2-lane and 4-lane instances sharing
// one lane stimulus generator; expected words are marker then 1, 2, 3, ...
module tb_usb4_lane_deskew;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en2 = 1'b0;
  logic       en4 = 1'b0;
  bit         sel4 = 1'b0;
  logic [7:0] sym [4];
  logic [3:0] vld;

  int n_tests = 0;
  int n_fail  = 0;

  usb4_lane_deskew_if #(.NUM_LANES(2), .DATA_W(8), .DEPTH(8)) b2 ();
  usb4_lane_deskew_if #(.NUM_LANES(4), .DATA_W(8), .DEPTH(8)) b4 ();

  assign b2.en            = en2;
  assign b2.lane_data_in  = {sym[1], sym[0]};
  assign b2.lane_valid_in = vld[1:0];
  assign b4.en            = en4;
  assign b4.lane_data_in  = {sym[3], sym[2], sym[1], sym[0]};
  assign b4.lane_valid_in = vld;

  usb4_lane_deskew #(.NUM_LANES(2), .DATA_W(8), .DEPTH(8), .MARKER(8'hF0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));
  usb4_lane_deskew #(.NUM_LANES(4), .DATA_W(8), .DEPTH(8), .MARKER(8'hF0)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave));

  logic       o_aligned, o_valid, o_err;
  logic [3:0] o_skew;
  logic [7:0] o_data [4];

  always_comb begin
    o_aligned = sel4 ? b4.aligned    : b2.aligned;
    o_valid   = sel4 ? b4.valid_out  : b2.valid_out;
    o_err     = sel4 ? b4.skew_err   : b2.skew_err;
    o_skew    = sel4 ? b4.skew_value : b2.skew_value;
    o_data[0] = sel4 ? b4.data_out[7:0]  : b2.data_out[7:0];
    o_data[1] = sel4 ? b4.data_out[15:8] : b2.data_out[15:8];
    o_data[2] = b4.data_out[23:16];
    o_data[3] = b4.data_out[31:24];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] expw(input int k);
    return (k == 0) ? 8'hF0 : 8'(k);
  endfunction

  task automatic check_clear(input int nl, input string tag);
    check({tag, "_aligned"}, o_aligned, 0);
    check({tag, "_valid"},   o_valid,   0);
    check({tag, "_err"},     o_err,     0);
    check({tag, "_skew"},    o_skew,    0);
    for (int l = 0; l < nl; l++) check($sformatf("%s_data_l%0d", tag, l), o_data[l], 0);
  endtask

  task automatic drop_en(input int nl);
    en2 = 1'b0;
    en4 = 1'b0;
    vld = '0;
    step();
    check_clear(nl, "en_off");
  endtask

  // Lane l is garbage (0x55) before cycle s[l], then marker, then 1, 2, ...
  // gap_lane drops valid for gap_len cycles starting at gap_start.
  task automatic run(input int nl, input int s0, input int s1, input int s2, input int s3,
                     input int n, input int gap_lane, input int gap_start, input int gap_len,
                     input bit exp_err);
    int s [4];
    int idx [4];
    int k, nvalid, ngap, maxs, mins;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    maxs = s[0];
    mins = s[0];
    for (int l = 0; l < 4; l++) idx[l] = 0;
    for (int l = 1; l < nl; l++) begin
      if (s[l] > maxs) maxs = s[l];
      if (s[l] < mins) mins = s[l];
    end
    k = 0; nvalid = 0; ngap = 0;
    for (int t = 0; t < n; t++) begin
      if (exp_err) begin
        check("err_run_aligned", o_aligned, 0);
        check("err_run_valid",   o_valid,   0);
      end else begin
        check($sformatf("aligned_t%0d", t), o_aligned, (t >= maxs + 1) ? 1 : 0);
        if (o_valid) begin
          for (int l = 0; l < nl; l++) check($sformatf("data_l%0d_w%0d", l, k), o_data[l], expw(k));
          k++;
          nvalid++;
        end else if (k > 0) begin
          ngap++;
          for (int l = 0; l < nl; l++) check($sformatf("hold_l%0d_t%0d", l, t), o_data[l], expw(k - 1));
        end
      end
      for (int l = 0; l < nl; l++) begin
        if (t < s[l]) begin
          vld[l] = 1'b1;
          sym[l] = 8'h55;
        end else if (l == gap_lane && t >= gap_start && t < gap_start + gap_len) begin
          vld[l] = 1'b0;
          sym[l] = 8'hAA;
        end else begin
          vld[l] = 1'b1;
          sym[l] = expw(idx[l]);
          idx[l]++;
        end
      end
      step();
    end
    if (exp_err) begin
      check("skew_err_set", o_err, 1);
      check("skew_value_err", o_skew, 0);
    end else begin
      check("valid_count", nvalid, n - (maxs + 2) - gap_len);
      check("gap_count",   ngap,   gap_len);
      check("skew_value",  o_skew, maxs - mins);
      check("skew_err_clr", o_err, 0);
    end
  endtask

  initial begin
    vld = '0;
    for (int l = 0; l < 4; l++) sym[l] = 8'h00;

    #2;
    check_clear(2, "rst2");
    sel4 = 1'b1;
    #1;
    check_clear(4, "rst4");
    sel4 = 1'b0;
    #1;
    rst_n = 1'b1;
    step();

    // zero skew
    en2 = 1'b1;
    run(2, 10, 10, 0, 0, 30, -1, 0, 0, 1'b0);
    // skew 3
    drop_en(2); en2 = 1'b1;
    run(2, 10, 13, 0, 0, 35, -1, 0, 0, 1'b0);
    // largest tolerated skew: lane0 FIFO runs full with push+pop
    drop_en(2); en2 = 1'b1;
    run(2, 3, 10, 0, 0, 30, -1, 0, 0, 1'b0);
    // skew of DEPTH cycles
    drop_en(2); en2 = 1'b1;
    run(2, 3, 11, 0, 0, 25, -1, 0, 0, 1'b1);
    // 2-cycle valid gap on lane1 while aligned
    drop_en(2); en2 = 1'b1;
    run(2, 5, 5, 0, 0, 30, 1, 15, 2, 1'b0);

    // async reset mid-stream, then re-hunt
    drop_en(2); en2 = 1'b1;
    run(2, 4, 4, 0, 0, 15, -1, 0, 0, 1'b0);
    check("pre_rst_aligned", o_aligned, 1);
    check("pre_rst_valid",   o_valid,   1);
    #2 rst_n = 1'b0;
    #1;
    check_clear(2, "async_rst");
    #2 rst_n = 1'b1;
    run(2, 4, 6, 0, 0, 30, -1, 0, 0, 1'b0);

    // 4 lanes: align, drop en mid-stream, re-hunt at skews 0/1/2/5
    en2  = 1'b0;
    sel4 = 1'b1;
    en4  = 1'b1;
    vld  = '0;
    step();
    run(4, 4, 4, 4, 4, 20, -1, 0, 0, 1'b0);
    drop_en(4); en4 = 1'b1;
    run(4, 10, 11, 12, 15, 40, -1, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb4_lane_deskew.md
Name: usb4_lane_deskew

Overview:
Parametrised multi-lane deskew buffer for the USB4 logical layer receive path. It sits between the per-lane symbol receivers and the lane-bonded logical layer. It absorbs inter-lane skew by aligning all lanes on a marker symbol (the first symbol after training), then presents lane-aligned words. It generalises the fixed two-lane alignment to N lanes with configurable word width, buffer depth and marker value, and adds skew measurement and sticky skew/overflow error reporting.

Parameters:
NUM_LANES, 2, number of bonded lanes (1..8)
DATA_W, 8, symbol width per lane in bits
DEPTH, 8, per-lane FIFO entries; power of 2, minimum 2
MARKER, 8'hF0, alignment marker symbol (DATA_W bits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  deskew enable; low flushes the block and holds it in IDLE
lane_data_in  in  NUM_LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
lane_valid_in  in  NUM_LANES  per-lane symbol valid
data_out  out  NUM_LANES*DATA_W  aligned words, same packing as input
valid_out  out  1  data_out holds one aligned word per lane
aligned  out  1  high while in ALIGNED
skew_err  out  1  sticky error: skew limit exceeded or FIFO overflow
skew_value  out  $clog2(DEPTH)+1  skew in cycles between first and last marker, latched at alignment

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFOs empty, per-lane captured flags cleared, state IDLE.
- One clock domain; all outputs registered.
- FSM states: IDLE, HUNT, ALIGNED, ERROR.
- IDLE: FIFOs held empty, outputs 0. Moves to HUNT on the first cycle with en=1.
- HUNT, per lane: valid symbols before that lane's marker are discarded.
  - The first valid MARKER sets the lane's captured flag and is written as FIFO entry 0.
  - Later valid symbols on a captured lane are written to its FIFO.
- Skew counter: starts at 0 on the cycle the first lane captures, and increments each following cycle while any lane is uncaptured.
- Markers on multiple lanes in the same cycle count as zero skew between those lanes.
- All lanes captured: state moves to ALIGNED at that edge, and skew_value latches the counter value.
- Skew limit: if the counter reaches DEPTH with a lane still uncaptured, state moves to ERROR. Tolerated skew is 0..DEPTH-1 cycles.
- ALIGNED: whenever every FIFO is non-empty, one entry is popped from every lane simultaneously and registered into data_out, with valid_out=1 on the next cycle.
  - If any FIFO is empty, valid_out=0 and data_out holds its last value.
  - Latency: the first valid_out (the marker word on every lane) occurs one cycle after aligned rises. aligned rises on the edge that samples the last marker.
- Later MARKER symbols in ALIGNED are passed through as ordinary data; there is no realignment.
- Overflow: a write to a full FIFO, with no pop in the same cycle, moves the state to ERROR. A simultaneous push and pop on a full FIFO is legal.
- ERROR: skew_err=1, aligned=0, valid_out=0, FIFOs flushed, writes ignored. The block stays in ERROR until en=0 or reset.
- en=0 in any state: next edge goes to IDLE, flushes FIFOs, clears the flags, aligned, valid_out, skew_err and skew_value. data_out goes to 0.
- en takes priority over all other events in the same cycle.
- Pointer arithmetic: log2(DEPTH)+1 bit pointers with wrap bit, giving full/empty distinction without a counter.

Test Plan:
- Zero skew (NUM_LANES=2, DEPTH=8): both lanes present 0xF0 at cycle 10, then 0x01, 0x02, ... continuously. Required: aligned=1 from cycle 11, skew_value=0, valid_out from cycle 12 with data_out={F0,F0}, then {01,01}, {02,02}, and no gaps.
- Skew 3: lane0 marker at cycle 10, lane1 marker at cycle 13, both followed by incrementing data. Required: skew_value=3, aligned rises at cycle 14, output pairs {F0,F0}, {01,01}, ... with matching values, and skew_err=0.
- Skew limit (DEPTH=8): lane1 delayed by 7 cycles gives alignment with skew_value=7. Lane1 delayed by 8 cycles gives skew_err=1, aligned never rises, and valid_out stays 0.
- Valid gap: in ALIGNED, drop lane1 valid for 2 cycles. Required: valid_out=0 for 2 cycles, then the stream resumes with no lost or duplicated words on either lane.
- en deasserted mid-ALIGNED, then reasserted with NUM_LANES=4 markers at skews 0/1/2/5. Required: outputs clear 1 cycle after en=0, re-hunt succeeds, and skew_value=5.
- rst_n pulsed low asynchronously mid-stream. Required: all outputs 0 immediately with no clock edge needed, and the block re-hunts after release.
